// File: rtl/pll_lock_detect_if.sv
// Signal bundle between the PLL core and the lock detector: synchronized
// feedback/VCO inputs in, phase/period measurements and lock status out.
interface pll_lock_detect_if;
   logic        fb;
   logic        vco;
   logic [15:0] phase_err;
   logic        err_valid;
   logic [15:0] period;
   logic        period_valid;
   logic        locked;
   logic        fb_lost;

   modport master (
      output fb, vco,
      input  phase_err, err_valid, period, period_valid, locked, fb_lost
   );

   modport slave (
      input  fb, vco,
      output phase_err, err_valid, period, period_valid, locked, fb_lost
   );
endinterface

// File: rtl/pll_lock_detect.sv
// PLL lock detector: pairs fb/vco rising edges into signed phase-error samples,
// measures the fb period, debounces lock and flags a lost feedback clock.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_IDLE     | no edge pending; waiting for the first edge of a pair
// ST_WAIT_VCO | fb edge seen, counting skew until the matching vco edge
// ST_WAIT_FB  | vco edge seen, counting skew until the matching fb edge
module pll_lock_detect #(
   parameter int WIN          = 4,
   parameter int LOCK_COUNT   = 8,
   parameter int UNLOCK_COUNT = 3,
   parameter int MAX_ERR      = 255,
   parameter int TIMEOUT      = 1000
) (
   input  logic              clk_50,
   input  logic              rst_n,
   pll_lock_detect_if.slave  bus
);

   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam int BW = $clog2(UNLOCK_COUNT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic signed [15:0] MAX_ERR_S  = 16'(MAX_ERR);
   localparam logic        [15:0] MAX_ERR_M1 = 16'(MAX_ERR - 1);
   localparam logic signed [15:0] WIN_S      = 16'(WIN);
   localparam logic [GW-1:0]      LOCK_N     = GW'(LOCK_COUNT);
   localparam logic [BW-1:0]      UNLOCK_N   = BW'(UNLOCK_COUNT);
   localparam logic [TW-1:0]      TMO_LOAD   = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_VCO = 2'd1,
      ST_WAIT_FB  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               fb_s_q, fb_s_d, fb_p_q, fb_p_d;
   logic               vco_s_q, vco_s_d, vco_p_q, vco_p_d;
   logic [15:0]        skew_q, skew_d;
   logic [15:0]        pcnt_q, pcnt_d;
   logic               hist_q, hist_d;
   logic [TW-1:0]      idle_q, idle_d;
   logic [GW-1:0]      good_q, good_d;
   logic [BW-1:0]      bad_q, bad_d;
   logic signed [15:0] phase_err_q, phase_err_d;
   logic               err_valid_q, err_valid_d;
   logic [15:0]        period_q, period_d;
   logic               period_valid_q, period_valid_d;
   logic               locked_q, locked_d;
   logic               fb_lost_q, fb_lost_d;

   logic               fb_rise, vco_rise;
   logic               emit, tmo, good;
   logic signed [15:0] emit_val;
   logic [GW-1:0]      good_inc;
   logic [BW-1:0]      bad_inc;

   always_comb begin
      state_d        = state_q;
      skew_d         = skew_q;
      pcnt_d         = pcnt_q;
      hist_d         = hist_q;
      idle_d         = idle_q;
      good_d         = good_q;
      bad_d          = bad_q;
      phase_err_d    = phase_err_q;
      err_valid_d    = 1'b0;
      period_d       = period_q;
      period_valid_d = 1'b0;
      locked_d       = locked_q;
      fb_lost_d      = fb_lost_q;
      emit           = 1'b0;
      emit_val       = '0;
      tmo            = 1'b0;

      fb_s_d  = bus.fb;
      fb_p_d  = fb_s_q;
      vco_s_d = bus.vco;
      vco_p_d = vco_s_q;

      fb_rise  = fb_s_q & ~fb_p_q;
      vco_rise = vco_s_q & ~vco_p_q;

      case (state_q)
         ST_IDLE: begin
            skew_d = '0;
            if (fb_rise && vco_rise) begin
               emit = 1'b1;
            end else if (fb_rise) begin
               state_d = ST_WAIT_VCO;
            end else if (vco_rise) begin
               state_d = ST_WAIT_FB;
            end
         end
         ST_WAIT_VCO: begin
            if (vco_rise) begin
               emit     = 1'b1;
               emit_val = $signed(skew_q + 16'd1);
               skew_d   = '0;
               state_d  = fb_rise ? ST_WAIT_VCO : ST_IDLE;
            end else if (fb_rise) begin
               // a second fb edge means the vco edge for the first was missed
               emit     = 1'b1;
               emit_val = MAX_ERR_S;
               skew_d   = '0;
            end else if (skew_q == MAX_ERR_M1) begin
               emit     = 1'b1;
               emit_val = MAX_ERR_S;
               skew_d   = '0;
               state_d  = ST_IDLE;
            end else begin
               skew_d = skew_q + 16'd1;
            end
         end
         ST_WAIT_FB: begin
            if (fb_rise) begin
               emit     = 1'b1;
               emit_val = -$signed(skew_q + 16'd1);
               skew_d   = '0;
               state_d  = vco_rise ? ST_WAIT_FB : ST_IDLE;
            end else if (vco_rise) begin
               emit     = 1'b1;
               emit_val = -MAX_ERR_S;
               skew_d   = '0;
            end else if (skew_q == MAX_ERR_M1) begin
               emit     = 1'b1;
               emit_val = -MAX_ERR_S;
               skew_d   = '0;
               state_d  = ST_IDLE;
            end else begin
               skew_d = skew_q + 16'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            skew_d  = '0;
         end
      endcase

      pcnt_d = (pcnt_q == 16'hFFFF) ? pcnt_q : pcnt_q + 16'd1;
      if (fb_rise) begin
         if (hist_q) begin
            period_d       = (pcnt_q == 16'hFFFF) ? pcnt_q : pcnt_q + 16'd1;
            period_valid_d = 1'b1;
         end
         hist_d = 1'b1;
         pcnt_d = '0;
      end

      // idle timer counts down from TIMEOUT-1 and fires once at terminal count
      if (fb_rise) begin
         idle_d    = TMO_LOAD;
         fb_lost_d = 1'b0;
      end else if (idle_q != '0) begin
         idle_d = idle_q - TW'(1);
      end else if (!fb_lost_q) begin
         tmo = 1'b1;
      end

      if (emit && !tmo) begin
         phase_err_d = emit_val;
         err_valid_d = 1'b1;
      end

      good     = (phase_err_q <= WIN_S) && (phase_err_q >= -WIN_S);
      good_inc = (good_q == LOCK_N) ? good_q : good_q + GW'(1);
      bad_inc  = (bad_q == UNLOCK_N) ? bad_q : bad_q + BW'(1);
      if (err_valid_q) begin
         if (good) begin
            good_d = good_inc;
            bad_d  = '0;
            if (good_inc == LOCK_N) locked_d = 1'b1;
         end else begin
            good_d = '0;
            bad_d  = bad_inc;
            if (locked_q && (bad_inc == UNLOCK_N)) locked_d = 1'b0;
         end
      end

      if (tmo) begin
         fb_lost_d = 1'b1;
         locked_d  = 1'b0;
         good_d    = '0;
         bad_d     = '0;
         state_d   = ST_IDLE;
         skew_d    = '0;
         hist_d    = 1'b0;
      end
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         fb_s_q         <= 1'b0;
         fb_p_q         <= 1'b0;
         vco_s_q        <= 1'b0;
         vco_p_q        <= 1'b0;
         skew_q         <= '0;
         pcnt_q         <= '0;
         hist_q         <= 1'b0;
         idle_q         <= TMO_LOAD;
         good_q         <= '0;
         bad_q          <= '0;
         phase_err_q    <= '0;
         err_valid_q    <= 1'b0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
         locked_q       <= 1'b0;
         fb_lost_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         fb_s_q         <= fb_s_d;
         fb_p_q         <= fb_p_d;
         vco_s_q        <= vco_s_d;
         vco_p_q        <= vco_p_d;
         skew_q         <= skew_d;
         pcnt_q         <= pcnt_d;
         hist_q         <= hist_d;
         idle_q         <= idle_d;
         good_q         <= good_d;
         bad_q          <= bad_d;
         phase_err_q    <= phase_err_d;
         err_valid_q    <= err_valid_d;
         period_q       <= period_d;
         period_valid_q <= period_valid_d;
         locked_q       <= locked_d;
         fb_lost_q      <= fb_lost_d;
      end
   end

   assign bus.phase_err    = phase_err_q;
   assign bus.err_valid    = err_valid_q;
   assign bus.period       = period_q;
   assign bus.period_valid = period_valid_q;
   assign bus.locked       = locked_q;
   assign bus.fb_lost      = fb_lost_q;

endmodule

// File: tb/tb_pll_lock_detect.sv
// Directed bench for pll_lock_detect: square-wave fb/vco patterns with
// hand-computed strobe positions, sample values, periods and lock timing.
module tb_pll_lock_detect;
   localparam int PER = 400;

   logic clk_50 = 1'b0;
   logic rst_n  = 1'b1;
   int   errors = 0;
   int   checks = 0;

   pll_lock_detect_if bus ();

   pll_lock_detect #(
      .WIN(4), .LOCK_COUNT(8), .UNLOCK_COUNT(3), .MAX_ERR(255), .TIMEOUT(1000)
   ) dut (
      .clk_50 (clk_50),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   always #10 clk_50 = ~clk_50;

   function automatic logic sq(input int n);
      return (n >= 0) && ((n % PER) < PER / 2);
   endfunction

   // drive inputs for the next edge, then observe just after it
   task automatic tick(input logic f, input logic v);
      bus.fb  = f;
      bus.vco = v;
      @(posedge clk_50);
      #1;
   endtask

   task automatic do_reset();
      bus.fb  = 1'b0;
      bus.vco = 1'b0;
      rst_n   = 1'b0;
      repeat (3) @(posedge clk_50);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [35:0] outs;
      bus.fb  = 1'b0;
      bus.vco = 1'b0;
      #5;
      rst_n = 1'b0;
      #1;
      outs = {bus.phase_err, bus.err_valid, bus.period, bus.period_valid, bus.locked, bus.fb_lost};
      checks++;
      if (outs !== 36'd0) begin
         errors++;
         $display("FAIL reset_async: outputs=%h expected=%h", outs, 36'd0);
      end
      for (int i = 0; i < 20; i++) begin
         tick(i[1], i[2]);
         outs = {bus.phase_err, bus.err_valid, bus.period, bus.period_valid, bus.locked, bus.fb_lost};
         checks++;
         if (outs !== 36'd0) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d: outputs=%h expected=%h", i, outs, 36'd0);
         end
      end
   endtask

   task automatic test_aligned();
      logic ev, pv, lk;
      do_reset();
      for (int n = 0; n < 12 * PER; n++) begin
         tick(sq(n), sq(n));
         ev = (n >= 1) && ((n - 1) % PER == 0);
         pv = ev && (n > PER);
         lk = (n >= 2 + 7 * PER);
         checks++;
         if (bus.err_valid !== ev) begin
            errors++;
            $display("FAIL aligned_err_valid n=%0d: got %b expected %b", n, bus.err_valid, ev);
         end
         if (ev) begin
            checks++;
            if (bus.phase_err !== 16'd0) begin
               errors++;
               $display("FAIL aligned_phase n=%0d: got %h expected 0000", n, bus.phase_err);
            end
         end
         checks++;
         if (bus.period_valid !== pv) begin
            errors++;
            $display("FAIL aligned_period_valid n=%0d: got %b expected %b", n, bus.period_valid, pv);
         end
         if (pv) begin
            checks++;
            if (bus.period !== 16'd400) begin
               errors++;
               $display("FAIL aligned_period n=%0d: got %0d expected 400", n, bus.period);
            end
         end
         checks++;
         if (bus.locked !== lk || bus.fb_lost !== 1'b0) begin
            errors++;
            $display("FAIL aligned_lock n=%0d: locked=%b fb_lost=%b expected locked=%b fb_lost=0",
                     n, bus.locked, bus.fb_lost, lk);
         end
      end
   endtask

   task automatic test_async_reset();
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.locked !== 1'b0 || bus.period !== 16'd0 || bus.phase_err !== 16'd0 || bus.fb_lost !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: locked=%b period=%0d phase=%h fb_lost=%b expected all 0",
                  bus.locked, bus.period, bus.phase_err, bus.fb_lost);
      end
      for (int i = 0; i < 6; i++) begin
         tick(i[0], i[0]);
         checks++;
         if (bus.err_valid !== 1'b0 || bus.period_valid !== 1'b0 || bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_hold cyc=%0d: err_valid=%b period_valid=%b locked=%b expected 0",
                     i, bus.err_valid, bus.period_valid, bus.locked);
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_lag_unlock();
      logic        ev, lk;
      logic [15:0] val;
      do_reset();
      for (int n = 0; n < 16 * PER; n++) begin
         if (n < 10 * PER) begin
            tick(sq(n), sq(n - 3));
            ev  = (n >= 4) && ((n - 4) % PER == 0);
            val = 16'd3;
         end else begin
            tick(sq(n), sq(n - 6));
            ev  = ((n - 7) % PER == 0);
            val = 16'd6;
         end
         lk = (n >= 5 + 7 * PER) && (n < 8 + 12 * PER);
         checks++;
         if (bus.err_valid !== ev) begin
            errors++;
            $display("FAIL lag_err_valid n=%0d: got %b expected %b", n, bus.err_valid, ev);
         end
         if (ev) begin
            checks++;
            if (bus.phase_err !== val) begin
               errors++;
               $display("FAIL lag_phase n=%0d: got %h expected %h", n, bus.phase_err, val);
            end
         end
         checks++;
         if (bus.locked !== lk) begin
            errors++;
            $display("FAIL lag_locked n=%0d: got %b expected %b", n, bus.locked, lk);
         end
      end
   endtask

   task automatic test_lead();
      logic ev;
      do_reset();
      for (int n = 0; n < 8 * PER; n++) begin
         tick(sq(n - 10), sq(n));
         ev = (n >= 11) && ((n - 11) % PER == 0);
         checks++;
         if (bus.err_valid !== ev) begin
            errors++;
            $display("FAIL lead_err_valid n=%0d: got %b expected %b", n, bus.err_valid, ev);
         end
         if (ev) begin
            checks++;
            if (bus.phase_err !== 16'hFFF6) begin
               errors++;
               $display("FAIL lead_phase n=%0d: got %h expected fff6", n, bus.phase_err);
            end
         end
         checks++;
         if (bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL lead_locked n=%0d: got %b expected 0", n, bus.locked);
         end
      end
   endtask

   task automatic test_missing_vco();
      logic ev, pv;
      do_reset();
      for (int n = 0; n < 4 * PER; n++) begin
         tick(sq(n), 1'b0);
         ev = (n >= 256) && ((n - 256) % PER == 0);
         pv = (n > PER) && ((n - 1) % PER == 0);
         checks++;
         if (bus.err_valid !== ev) begin
            errors++;
            $display("FAIL missing_err_valid n=%0d: got %b expected %b", n, bus.err_valid, ev);
         end
         if (ev) begin
            checks++;
            if (bus.phase_err !== 16'd255) begin
               errors++;
               $display("FAIL missing_phase n=%0d: got %h expected 00ff", n, bus.phase_err);
            end
         end
         checks++;
         if (bus.period_valid !== pv || (pv && bus.period !== 16'd400)) begin
            errors++;
            $display("FAIL missing_period n=%0d: valid=%b period=%0d expected valid=%b period=400",
                     n, bus.period_valid, bus.period, pv);
         end
         checks++;
         if (bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL missing_locked n=%0d: got %b expected 0", n, bus.locked);
         end
      end
   endtask

   task automatic test_fb_loss();
      logic f, ev, lk, lost, pv;
      do_reset();
      for (int n = 0; n < 5000; n++) begin
         f = (n < 10 * PER) ? sq(n) : 1'b0;
         tick(f, f);
         ev   = (n >= 1) && (n <= 9 * PER + 1) && ((n - 1) % PER == 0);
         lost = (n >= 4601);
         lk   = (n >= 2 + 7 * PER) && (n < 4601);
         checks++;
         if (bus.err_valid !== ev) begin
            errors++;
            $display("FAIL loss_err_valid n=%0d: got %b expected %b", n, bus.err_valid, ev);
         end
         checks++;
         if (bus.fb_lost !== lost || bus.locked !== lk) begin
            errors++;
            $display("FAIL loss_timeout n=%0d: fb_lost=%b locked=%b expected fb_lost=%b locked=%b",
                     n, bus.fb_lost, bus.locked, lost, lk);
         end
      end
      for (int m = 0; m < 9 * PER; m++) begin
         tick(sq(m), sq(m));
         lost = (m == 0);
         pv   = (m > PER) && ((m - 1) % PER == 0);
         lk   = (m >= 2 + 7 * PER);
         checks++;
         if (bus.fb_lost !== lost) begin
            errors++;
            $display("FAIL recover_fb_lost m=%0d: got %b expected %b", m, bus.fb_lost, lost);
         end
         checks++;
         if (bus.period_valid !== pv || (pv && bus.period !== 16'd400)) begin
            errors++;
            $display("FAIL recover_period m=%0d: valid=%b period=%0d expected valid=%b period=400",
                     m, bus.period_valid, bus.period, pv);
         end
         checks++;
         if (bus.locked !== lk) begin
            errors++;
            $display("FAIL recover_locked m=%0d: got %b expected %b", m, bus.locked, lk);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [39:0] fbp, vcop;
      int          ev_n[7]  = '{6, 10, 17, 21, 28, 31, 35};
      logic [15:0] ev_v[7]  = '{16'd5, 16'd4, 16'd255, 16'd4, 16'hFF01, 16'hFFFD, 16'd0};
      int          pv_n[5]  = '{6, 13, 17, 31, 35};
      logic [15:0] pv_v[5]  = '{16'd5, 16'd7, 16'd4, 16'd14, 16'd4};
      int          ei = 0;
      int          pi = 0;
      logic        ev, pv;
      fbp  = '0;
      vcop = '0;
      fbp[0] = 1'b1;  fbp[5] = 1'b1;  fbp[12] = 1'b1;
      fbp[16] = 1'b1; fbp[30] = 1'b1; fbp[34] = 1'b1;
      vcop[5] = 1'b1;  vcop[9] = 1'b1;  vcop[20] = 1'b1;
      vcop[24] = 1'b1; vcop[27] = 1'b1; vcop[34] = 1'b1;
      do_reset();
      for (int n = 0; n < 40; n++) begin
         tick(fbp[n], vcop[n]);
         ev = (ei < 7) && (ev_n[ei] == n);
         pv = (pi < 5) && (pv_n[pi] == n);
         checks++;
         if (bus.err_valid !== ev) begin
            errors++;
            $display("FAIL pair_err_valid n=%0d: got %b expected %b", n, bus.err_valid, ev);
         end
         if (ev) begin
            checks++;
            if (bus.phase_err !== ev_v[ei]) begin
               errors++;
               $display("FAIL pair_phase n=%0d: got %h expected %h", n, bus.phase_err, ev_v[ei]);
            end
            ei++;
         end
         checks++;
         if (bus.period_valid !== pv) begin
            errors++;
            $display("FAIL pair_period_valid n=%0d: got %b expected %b", n, bus.period_valid, pv);
         end
         if (pv) begin
            checks++;
            if (bus.period !== pv_v[pi]) begin
               errors++;
               $display("FAIL pair_period n=%0d: got %0d expected %0d", n, bus.period, pv_v[pi]);
            end
            pi++;
         end
         checks++;
         if (bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL pair_locked n=%0d: got %b expected 0", n, bus.locked);
         end
      end
   endtask

   initial begin
      bus.fb  = 1'b0;
      bus.vco = 1'b0;
      test_reset();
      test_aligned();
      test_async_reset();
      test_lag_unlock();
      test_lead();
      test_missing_vco();
      test_fb_loss();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
